freqdiv_autorange: RTL

- Sequential controller that drives the 4-bit tap select of the 16-tap VCO frequency divider.
- Measures the selected divided clock by counting its rising edges over a programmable window of Clk cycles.
- Auto-ranges: steps the select from fastest tap (0) toward slower taps until the edge count is at or below a high threshold.
- Reports the final select, the final count and a range-error flag.
- Sits between the system digital controller (Clk domain) and the divider/mux. Fdiv_in arrives already 2-flop synchronised into Clk.

---
 rtl/freqdiv_autorange.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/freqdiv_autorange.sv
// Auto-ranging controller for the 16-tap VCO divider: steps the tap select from
// fastest toward slower taps until the edge count in a timed window is in range.
module freqdiv_autorange #(
    parameter int unsigned WIN_W      = 16,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned SETTLE_CYC = 8
) (
    input  logic             Clk,
    input  logic             Resetn,
    input  logic             Start,
    input  logic             Abort,
    input  logic [WIN_W-1:0] Win_len,
    input  logic [CNT_W-1:0] Cnt_hi,
    input  logic [CNT_W-1:0] Cnt_lo,
    input  logic             Fdiv_in,
    output logic [3:0]       Fsel,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] Count,
    output logic             Range_err
);

    localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);
    localparam int unsigned TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_MEAS   = 3'd2;
    localparam logic [2:0] ST_EVAL   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    logic [2:0]       state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] hi_q, hi_d;
    logic [CNT_W-1:0] lo_q, lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prev_q, prev_d;
    logic [3:0]       fsel_q, fsel_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rerr_q, rerr_d;

    logic             rise_c;
    logic [TMR_W-1:0] win_last_c;

    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            win_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            prev_q  <= 1'b0;
            fsel_q  <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            win_q   <= win_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            prev_q  <= prev_d;
            fsel_q  <= fsel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            count_q <= count_d;
            rerr_q  <= rerr_d;
        end
    end

    // A zero window length is treated as a one-cycle window.
    always_comb begin
        rise_c     = Fdiv_in & ~prev_q;
        win_last_c = (win_q == '0) ? '0 : TMR_W'(win_q - WIN_W'(1));
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        win_d   = win_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        prev_d  = Fdiv_in;
        fsel_d  = fsel_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        count_d = count_q;
        rerr_d  = rerr_q;

        case (state_q)
            ST_IDLE: begin
                if (Start && !Abort) begin
                    win_d   = Win_len;
                    hi_d    = Cnt_hi;
                    lo_d    = Cnt_lo;
                    fsel_d  = 4'd0;
                    rerr_d  = 1'b0;
                    busy_d  = 1'b1;
                    tmr_d   = '0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (tmr_q == SETTLE_LAST) begin
                    tmr_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_MEAS;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_MEAS: begin
                if (rise_c && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (tmr_q == win_last_c) begin
                    tmr_d   = '0;
                    state_d = ST_EVAL;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_EVAL: begin
                // Result is published on the edge leaving EVAL; Busy drops there too.
                if ((cnt_q > hi_q) && (fsel_q != 4'd15)) begin
                    fsel_d  = fsel_q + 4'd1;
                    tmr_d   = '0;
                    state_d = ST_SETTLE;
                end else begin
                    if ((cnt_q > hi_q) || (cnt_q < lo_q)) begin
                        rerr_d = 1'b1;
                    end
                    done_d  = 1'b1;
                    count_d = cnt_q;
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (Abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            fsel_d  = fsel_q;
            count_d = count_q;
            rerr_d  = rerr_q;
        end
    end

    assign Fsel      = fsel_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Count     = count_q;
    assign Range_err = rerr_q;

endmodule
